game_state_fsm: RTL and testbench

Game-flow controller that sits directly downstream of the collision comparator and the raccoon controller's level output.
- Turns raw overlap and level changes into accepted hits, lives, invulnerability, level-up pauses and game-over.
- Drives freeze, respawn and flash controls back to the raccoon/car controllers and to the VGA renderer.
- Owns the lives count for the game.

---
 rtl/game_state_fsm_if.sv | 27 ++
 rtl/game_state_fsm.sv | 169 ++++++++++++++++
 tb/tb_game_state_fsm.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/game_state_fsm_if.sv
// Signal bundle between the game-flow controller, the collision comparator,
// the raccoon/car controllers and the VGA renderer.
interface game_state_fsm_if;
  logic       i_Collision;
  logic [3:0] i_Level;
  logic       i_Start;
  logic [2:0] o_State;
  logic [2:0] o_Lives;
  logic       o_Hit_Pulse;
  logic       o_Respawn;
  logic       o_Level_Up;
  logic       o_Freeze;
  logic       o_Flash;
  logic       o_Game_Over;

  modport master (
    output i_Collision, i_Level, i_Start,
    input  o_State, o_Lives, o_Hit_Pulse, o_Respawn, o_Level_Up,
           o_Freeze, o_Flash, o_Game_Over
  );

  modport slave (
    input  i_Collision, i_Level, i_Start,
    output o_State, o_Lives, o_Hit_Pulse, o_Respawn, o_Level_Up,
           o_Freeze, o_Flash, o_Game_Over
  );
endinterface

// File: rtl/game_state_fsm.sv
// Game-flow controller: accepted hits, lives, invulnerability, level-up pause, game-over.
// Define EXTRA_LIFE_EN to award a life (saturating at 7) on every accepted level change.
module game_state_fsm #(
  parameter int START_LIVES    = 3,
  parameter int HIT_TICKS      = 50000000,
  parameter int FLASH_TICKS    = 3125000,
  parameter int LEVEL_UP_TICKS = 25000000
) (
  input logic             i_Clk,
  input logic             i_Reset,
  game_state_fsm_if.slave bus
);

  localparam int MAX_HL    = (HIT_TICKS > LEVEL_UP_TICKS) ? HIT_TICKS : LEVEL_UP_TICKS;
  localparam int MAX_TICKS = (MAX_HL > FLASH_TICKS) ? MAX_HL : FLASH_TICKS;
  localparam int TW        = $clog2(MAX_TICKS) + 1;

  localparam logic [TW-1:0] HIT_LOAD   = TW'(HIT_TICKS - 1);
  localparam logic [TW-1:0] FLASH_LOAD = TW'(FLASH_TICKS - 1);
  localparam logic [TW-1:0] LU_LOAD    = TW'(LEVEL_UP_TICKS - 1);
  localparam logic [TW-1:0] T_ONE      = TW'(1);
  localparam logic [2:0]    LIVES_INIT = 3'(START_LIVES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    HIT       = 3'd2,
    LEVEL_UP  = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t        r_State, w_State;
  logic [TW-1:0] r_Timer, w_Timer;
  logic [TW-1:0] r_Flash_Timer, w_Flash_Timer;
  logic [2:0]    r_Lives, w_Lives;
  logic          r_Hit_Pulse, w_Hit_Pulse;
  logic          r_Respawn, w_Respawn;
  logic          r_Level_Up, w_Level_Up;
  logic          r_Flash, w_Flash;
  logic          r_Freeze, w_Freeze;
  logic          r_Game_Over, w_Game_Over;
  logic          r_Coll;
  logic [3:0]    r_Level_Prev;
  logic          w_Level_Chg;

  assign w_Level_Chg = (bus.i_Level != r_Level_Prev);

  always_comb begin
    // NOTE: every w_ signal gets a default before the case so no path can infer a latch.
    w_State       = r_State;
    w_Timer       = r_Timer;
    w_Flash_Timer = r_Flash_Timer;
    w_Lives       = r_Lives;
    w_Flash       = r_Flash;
    w_Hit_Pulse   = 1'b0;
    w_Respawn     = 1'b0;
    w_Level_Up    = 1'b0;

    unique case (r_State)
      IDLE: begin
        if (bus.i_Start) begin
          w_State   = PLAY;
          w_Respawn = 1'b1;
        end
      end

      PLAY: begin
        // A collision outranks a same-cycle level change, which is then lost.
        if (r_Coll) begin
          w_Hit_Pulse = 1'b1;
          if (r_Lives > 3'd1) begin
            w_Lives       = r_Lives - 3'd1;
            w_Respawn     = 1'b1;
            w_Timer       = HIT_LOAD;
            w_Flash_Timer = FLASH_LOAD;
            w_Flash       = 1'b1;
            w_State       = HIT;
          end else begin
            w_Lives = 3'd0;
            w_State = GAME_OVER;
          end
        end else if (w_Level_Chg) begin
          w_Level_Up = 1'b1;
          w_Timer    = LU_LOAD;
          w_State    = LEVEL_UP;
`ifdef EXTRA_LIFE_EN
          if (r_Lives != 3'd7) w_Lives = r_Lives + 3'd1;
`else
          w_Lives = r_Lives;
`endif
        end
      end

      HIT: begin
        if (r_Timer == '0) begin
          w_State = PLAY;
          w_Flash = 1'b0;
        end else begin
          w_Timer = r_Timer - T_ONE;
          if (r_Flash_Timer == '0) begin
            w_Flash       = ~r_Flash;
            w_Flash_Timer = FLASH_LOAD;
          end else begin
            w_Flash_Timer = r_Flash_Timer - T_ONE;
          end
        end
      end

      LEVEL_UP: begin
        if (r_Timer == '0) w_State = PLAY;
        else               w_Timer = r_Timer - T_ONE;
      end

      GAME_OVER: begin
        if (bus.i_Start) begin
          w_Lives   = LIVES_INIT;
          w_Respawn = 1'b1;
          w_State   = PLAY;
        end
      end

      default: w_State = IDLE;
    endcase

    // Level-style outputs follow the state being entered so they stay registered.
    w_Freeze    = (w_State == IDLE) || (w_State == LEVEL_UP) || (w_State == GAME_OVER);
    w_Game_Over = (w_State == GAME_OVER);
  end

  always_ff @(posedge i_Clk) begin
    // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
    r_Level_Prev <= bus.i_Level;
    if (i_Reset) begin
      r_State       <= IDLE;
      r_Timer       <= '0;
      r_Flash_Timer <= '0;
      r_Lives       <= LIVES_INIT;
      r_Hit_Pulse   <= 1'b0;
      r_Respawn     <= 1'b0;
      r_Level_Up    <= 1'b0;
      r_Flash       <= 1'b0;
      r_Freeze      <= 1'b1;
      r_Game_Over   <= 1'b0;
      r_Coll        <= 1'b0;
    end else begin
      r_State       <= w_State;
      r_Timer       <= w_Timer;
      r_Flash_Timer <= w_Flash_Timer;
      r_Lives       <= w_Lives;
      r_Hit_Pulse   <= w_Hit_Pulse;
      r_Respawn     <= w_Respawn;
      r_Level_Up    <= w_Level_Up;
      r_Flash       <= w_Flash;
      r_Freeze      <= w_Freeze;
      r_Game_Over   <= w_Game_Over;
      r_Coll        <= bus.i_Collision;
    end
  end

  assign bus.o_State     = r_State;
  assign bus.o_Lives     = r_Lives;
  assign bus.o_Hit_Pulse = r_Hit_Pulse;
  assign bus.o_Respawn   = r_Respawn;
  assign bus.o_Level_Up  = r_Level_Up;
  assign bus.o_Freeze    = r_Freeze;
  assign bus.o_Flash     = r_Flash;
  assign bus.o_Game_Over = r_Game_Over;

endmodule

// File: tb/tb_game_state_fsm.sv
// Scenario bench for game_state_fsm with short tick overrides; expected output
// words are queued as each cycle's stimulus is driven and popped after the edge.
`timescale 1ns/1ps
module tb_game_state_fsm;

  localparam int HIT_T   = 8;
  localparam int FLASH_T = 2;
  localparam int LU_T    = 4;
  localparam int START_L = 3;
`ifdef EXTRA_LIFE_EN
  localparam int XL = 1;
`else
  localparam int XL = 0;
`endif

  // Packed view: {state, lives, hit, respawn, level_up, freeze, flash, game_over}
  typedef logic [11:0] obs_t;

  logic       i_Clk = 1'b0;
  logic       i_Reset;
  logic [3:0] cur_lvl;
  obs_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  game_state_fsm_if bus();

  game_state_fsm #(
    .START_LIVES   (START_L),
    .HIT_TICKS     (HIT_T),
    .FLASH_TICKS   (FLASH_T),
    .LEVEL_UP_TICKS(LU_T)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .bus    (bus)
  );

  always #5 i_Clk = ~i_Clk;

  function automatic obs_t mk(input int st, input int lv, input bit hit, input bit resp,
                              input bit lvl, input bit frz, input bit fl, input bit go);
    return {3'(st), 3'(lv), hit, resp, lvl, frz, fl, go};
  endfunction

  function automatic obs_t observe();
    return {bus.o_State, bus.o_Lives, bus.o_Hit_Pulse, bus.o_Respawn,
            bus.o_Level_Up, bus.o_Freeze, bus.o_Flash, bus.o_Game_Over};
  endfunction

  // Applies one cycle of stimulus, queues what should appear after the edge,
  // then waits until just after that edge.
  task automatic drive(input bit rst, input bit coll, input bit start,
                       input logic [3:0] lvl, input obs_t e);
    i_Reset         = rst;
    bus.i_Collision = coll;
    bus.i_Start     = start;
    bus.i_Level     = lvl;
    exp_q.push_back(e);
    @(posedge i_Clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t got, e;
    cur_lvl = 4'd1;
    for (int k = 1; k <= 4; k++) begin
      drive(k <= 2, k == 3, 1'b0, cur_lvl, mk(0, START_L, 0, 0, 0, 1, 0, 0));
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_start();
    obs_t got, e;
    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b0, k == 1, cur_lvl, mk(1, START_L, 0, k == 1, 0, 0, 0, 0));
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL start[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  // Overlap held for 12 cycles: hit on edge 2, invulnerable 8 cycles with the
  // blink pattern 1,1,0,0,1,1,0,0, back to PLAY, second hit on the next edge.
  task automatic test_hit();
    obs_t got, e;
    for (int k = 1; k <= 20; k++) begin
      int j;
      if (k == 1) e = mk(1, 3, 0, 0, 0, 0, 0, 0);
      else if (k <= 9) begin
        j = k - 2;
        e = mk(2, 2, k == 2, k == 2, 0, 0, ((j / 2) % 2) == 0, 0);
      end else if (k == 10) e = mk(1, 2, 0, 0, 0, 0, 0, 0);
      else if (k <= 18) begin
        j = k - 11;
        e = mk(2, 1, k == 11, k == 11, 0, 0, ((j / 2) % 2) == 0, 0);
      end else e = mk(1, 1, 0, 0, 0, 0, 0, 0);
      drive(1'b0, k <= 12, 1'b0, cur_lvl, e);
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL hit[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  task automatic test_game_over();
    obs_t got, e;
    obs_t tbl [6];
    tbl[0] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk(4, 0, 1, 0, 0, 1, 0, 1);
    tbl[2] = mk(4, 0, 0, 0, 0, 1, 0, 1);
    tbl[3] = mk(4, 0, 0, 0, 0, 1, 0, 1);
    tbl[4] = mk(1, START_L, 0, 1, 0, 0, 0, 0);
    tbl[5] = mk(1, START_L, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      drive(1'b0, k == 0, k == 4, cur_lvl, tbl[k]);
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL game_over[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  // Level steps 1->2, 3->9, 9->1. During the first pause a collision and a
  // further level change arrive and must both be ignored.
  task automatic test_level_up();
    obs_t got, e;
    logic [3:0] targets [3];
    targets[0] = 4'd2;
    targets[1] = 4'd9;
    targets[2] = 4'd1;
    for (int n = 0; n < 3; n++) begin
      int lv;
      lv = START_L + XL * (n + 1);
      for (int c = 0; c < 6; c++) begin
        if (c == 0) cur_lvl = targets[n];
        if (n == 0 && c == 2) cur_lvl = 4'd3;
        if (c == 0)      e = mk(3, lv, 0, 0, 1, 1, 0, 0);
        else if (c <= 3) e = mk(3, lv, 0, 0, 0, 1, 0, 0);
        else             e = mk(1, lv, 0, 0, 0, 0, 0, 0);
        drive(1'b0, n == 0 && c == 1, 1'b0, cur_lvl, e);
        got = observe();
        e   = exp_q.pop_front();
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL level_up[%0d.%0d] got=%h want=%h", n, c, got, e);
        end
      end
    end
  endtask

  // Collision asserted one cycle before the level change so that the FSM sees
  // the registered overlap and the level change on the same edge.
  task automatic test_coll_level_same();
    obs_t got, e;
    int l0;
    l0 = START_L + 3 * XL;
    for (int k = 1; k <= 4; k++) begin
      if (k == 2) cur_lvl = 4'd2;
      if (k == 3) cur_lvl = 4'd3;
      if (k == 1)      e = mk(1, l0, 0, 0, 0, 0, 0, 0);
      else if (k == 2) e = mk(2, l0 - 1, 1, 1, 0, 0, 1, 0);
      else if (k == 3) e = mk(2, l0 - 1, 0, 0, 0, 0, 1, 0);
      else             e = mk(2, l0 - 1, 0, 0, 0, 0, 0, 0);
      drive(1'b0, k == 1, 1'b0, cur_lvl, e);
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL coll_level_same[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  // Entered on HIT cycle 3 of 8; reset must abort at once, then a restart
  // must give a clean PLAY with no leftover level-up.
  task automatic test_reset_mid_hit();
    obs_t got, e;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) cur_lvl = 4'd5;
      if (k <= 2)      e = mk(0, START_L, 0, 0, 0, 1, 0, 0);
      else if (k == 3) e = mk(1, START_L, 0, 1, 0, 0, 0, 0);
      else             e = mk(1, START_L, 0, 0, 0, 0, 0, 0);
      drive(k == 1, 1'b0, k == 3, cur_lvl, e);
      got = observe();
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL reset_mid_hit[%0d] got=%h want=%h", k, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hit();
    test_game_over();
    test_level_up();
    test_coll_level_same();
    test_reset_mid_hit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
